// File: rtl/sd_dfc_rcrx_if.sv
// Handshake bundle for the delayed-flow-control receiver.
// Producer side: p_data/p_vld in, p_fc_n back. Consumer side: c_data/c_srdy out, c_drdy in.
// The receiver uses the slave view; the producer/consumer environment uses the master view.
interface sd_dfc_rcrx_if #(
    parameter int width = 8
);
    logic [width-1:0] p_data;
    logic             p_vld;
    logic             p_fc_n;
    logic [width-1:0] c_data;
    logic             c_srdy;
    logic             c_drdy;

    modport master (
        output p_data, p_vld, c_drdy,
        input  p_fc_n, c_data, c_srdy
    );

    modport slave (
        input  p_data, p_vld, c_drdy,
        output p_fc_n, c_data, c_srdy
    );
endinterface

// File: rtl/sd_dfc_rcrx.sv
// Delayed-flow-control receiver: a skid FIFO behind a rate-controlled DFC sender.
// p_fc_n is registered and drops while `skid` entries are still free, so that
// beats already in flight land safely. Occupancy, a high-water mark and a sticky
// overflow flag are exported for the cfg slave.
module sd_dfc_rcrx #(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int skid  = 3,
    parameter int asz   = $clog2(depth + 1)
) (
    input  logic           clk,
    input  logic           rst,
    sd_dfc_rcrx_if.slave   bus,
    output logic [asz-1:0] usage,
    output logic [asz-1:0] hwm,
    output logic           overflow,
    input  logic           clr_mon
);
    localparam int psz = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [psz-1:0] last_ptr = psz'(depth - 1);
    localparam logic [asz-1:0] depth_c  = asz'(depth);
    localparam logic [asz-1:0] skid_c   = asz'(skid);

    logic [width-1:0] mem [depth];
    logic [psz-1:0]   wr_ptr;
    logic [psz-1:0]   rd_ptr;
    logic [asz-1:0]   count;
    logic [asz-1:0]   nxt_count;
    logic [asz-1:0]   free_nxt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign bus.c_srdy = (count != '0);
    assign bus.c_data = mem[rd_ptr];
    assign usage      = count;

    // Accept/drop decision and next occupancy; a full FIFO still accepts when it pops the same cycle.
    always_comb begin
        full      = (count == depth_c);
        pop       = bus.c_srdy && bus.c_drdy;
        push      = bus.p_vld && (!full || pop);
        drop      = bus.p_vld && !push;
        nxt_count = count + asz'(push) - asz'(pop);
        free_nxt  = depth_c - nxt_count;
    end

    // Occupancy, pointers (explicit wrap at depth-1) and registered flow control.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bus.p_fc_n <= 1'b0;
        end else begin
            count      <= nxt_count;
            bus.p_fc_n <= (free_nxt > skid_c);
            if (push) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; no reset needed since contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.p_data;
        end
    end

    // Monitor: high-water mark and sticky overflow; clr_mon reloads from this cycle's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm      <= '0;
            overflow <= 1'b0;
        end else if (clr_mon) begin
            hwm      <= nxt_count;
            overflow <= drop;
        end else begin
            hwm      <= (nxt_count > hwm) ? nxt_count : hwm;
            overflow <= overflow || drop;
        end
    end

`ifndef SYNTHESIS
    logic           fc_d;
    logic [asz-1:0] win;
    logic           fall_now;

    assign fall_now = fc_d && !bus.p_fc_n;

    // Tracks the skid window: the first `skid` cycles after p_fc_n falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_d <= 1'b0;
            win  <= '0;
        end else begin
            fc_d <= bus.p_fc_n;
            if (fall_now) begin
                win <= skid_c - asz'(1);
            end else if (win != '0) begin
                win <= win - asz'(1);
            end
        end
    end

    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) pop |-> (count != '0));
    a_count_range  : assert property (@(posedge clk) disable iff (rst) count <= depth_c);
    a_skid_window  : assert property (@(posedge clk) disable iff (rst) !((fall_now || win != '0) && drop));
`endif
endmodule

// File: tb/tb_sd_dfc_rcrx.sv
// Bench for sd_dfc_rcrx: two instances (depth 8/skid 3 and depth 6/skid 2) checked every
// cycle against a queue-based model, plus hand-computed expectations for the key scenarios.
module tb_sd_dfc_rcrx;
    localparam int D0 = 8;
    localparam int S0 = 3;
    localparam int D1 = 6;
    localparam int S1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] usage0, hwm0;
    logic       ovf0;
    logic [2:0] usage1, hwm1;
    logic       ovf1;

    sd_dfc_rcrx_if #(.width(8)) b0 ();
    sd_dfc_rcrx_if #(.width(8)) b1 ();

    sd_dfc_rcrx #(.width(8), .depth(D0), .skid(S0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .usage(usage0), .hwm(hwm0),
        .overflow(ovf0), .clr_mon(clr)
    );

    sd_dfc_rcrx #(.width(8), .depth(D1), .skid(S1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .usage(usage1), .hwm(hwm1),
        .overflow(ovf1), .clr_mon(clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         hwm_m [2];
    bit         ovf_m [2];
    bit         fc_m  [2];
    bit         chk_en = 1'b0;

    task automatic model_step(input int u, input int depth, input int skid, input logic r,
                              input logic vld, input logic [7:0] d, input logic drdy,
                              input logic c, ref logic [7:0] q[$]);
        bit pop, push, drop;
        int sz;
        if (r) begin
            q.delete();
            hwm_m[u] = 0;
            ovf_m[u] = 1'b0;
            fc_m[u]  = 1'b0;
            return;
        end
        sz   = q.size();
        pop  = (sz > 0) && drdy;
        push = vld && ((sz < depth) || pop);
        drop = vld && !push;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        sz       = q.size();
        fc_m[u]  = (depth - sz) > skid;
        hwm_m[u] = c ? sz : ((sz > hwm_m[u]) ? sz : hwm_m[u]);
        ovf_m[u] = c ? drop : (ovf_m[u] || drop);
    endtask

    always @(posedge clk) begin
        model_step(0, D0, S0, rst, b0.p_vld, b0.p_data, b0.c_drdy, clr, q0);
        model_step(1, D1, S1, rst, b1.p_vld, b1.p_data, b1.c_drdy, clr, q1);
        chk_en = 1'b1;
    end

    task automatic cmp_unit(input int u, input logic srdy, input logic [7:0] data, input logic fc,
                            input logic [31:0] use_v, input logic [31:0] hw, input logic ov,
                            ref logic [7:0] q[$]);
        check($sformatf("u%0d_srdy", u), srdy, q.size() > 0);
        if (q.size() > 0) check($sformatf("u%0d_data", u), data, q[0]);
        check($sformatf("u%0d_usage", u), use_v, q.size());
        check($sformatf("u%0d_hwm", u), hw, hwm_m[u]);
        check($sformatf("u%0d_overflow", u), ov, ovf_m[u]);
        check($sformatf("u%0d_fc_n", u), fc, fc_m[u]);
    endtask

    // Stream-order tracking for the wrap scenario on the depth-6 instance.
    bit rx_en  = 1'b0;
    int rx_cnt = 0;

    // Single compare process: outputs vs model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_unit(0, b0.c_srdy, b0.c_data, b0.p_fc_n, usage0, hwm0, ovf0, q0);
            cmp_unit(1, b1.c_srdy, b1.c_data, b1.p_fc_n, usage1, hwm1, ovf1, q1);
            if (rx_en && b1.c_srdy && b1.c_drdy) begin
                check("t4_order", b1.c_data, 8'h40 + rx_cnt);
                rx_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            b0.p_vld  = 1'b1;
            b0.p_data = base + 8'(i);
            tick();
        end
        b0.p_vld = 1'b0;
    endtask

    task automatic drain_chk(input int n, input logic [7:0] base, input string name);
        b0.c_drdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(name, b0.c_data, base + 8'(i));
            tick();
        end
        b0.c_drdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        b0.p_vld = 1'b0; b0.p_data = '0; b0.c_drdy = 1'b0;
        b1.p_vld = 1'b0; b1.p_data = '0; b1.c_drdy = 1'b0;
        tick();
        check("rst_usage", usage0, 0);
        check("rst_srdy", b0.c_srdy, 0);
        check("rst_fc_n", b0.p_fc_n, 0);
        check("rst_hwm", hwm0, 0);
        check("rst_ovf", ovf0, 0);
        rst = 1'b0;
        tick();
        check("fc_after_rst", b0.p_fc_n, 1);

        // 1: fill
        push_n(4, 8'h01);
        check("t1_fc_4", b0.p_fc_n, 1);
        push_n(1, 8'h05);
        check("t1_fc_5", b0.p_fc_n, 0);
        check("t1_usage5", usage0, 5);
        push_n(3, 8'h06);
        check("t1_usage8", usage0, 8);
        check("t1_ovf", ovf0, 0);
        check("t1_hwm", hwm0, 8);

        // 2: overflow then drain
        push_n(1, 8'h09);
        check("t2_ovf", ovf0, 1);
        check("t2_usage", usage0, 8);
        drain_chk(8, 8'h01, "t2_drain");
        check("t2_empty", b0.c_srdy, 0);

        // 3: push and pop while full
        clr = 1'b1; tick(); clr = 1'b0;
        push_n(8, 8'h11);
        b0.p_vld = 1'b1; b0.p_data = 8'h19; b0.c_drdy = 1'b1;
        tick();
        b0.p_vld = 1'b0; b0.c_drdy = 1'b0;
        check("t3_usage", usage0, 8);
        check("t3_ovf", ovf0, 0);
        drain_chk(8, 8'h12, "t3_drain");

        // 5: reset mid-stream
        push_n(9, 8'h20);
        drain_chk(4, 8'h20, "t5_drain");
        check("t5_usage4", usage0, 4);
        check("t5_ovf1", ovf0, 1);
        rst = 1'b1; b0.p_vld = 1'b1; b0.p_data = 8'hEE;
        tick();
        rst = 1'b0; b0.p_vld = 1'b0;
        check("t5_usage", usage0, 0);
        check("t5_srdy", b0.c_srdy, 0);
        check("t5_ovf", ovf0, 0);
        check("t5_hwm", hwm0, 0);
        check("t5_fc0", b0.p_fc_n, 0);
        tick();
        check("t5_fc1", b0.p_fc_n, 1);

        // 6: monitor clear
        push_n(7, 8'h30);
        drain_chk(5, 8'h30, "t6_drain");
        check("t6_hwm7", hwm0, 7);
        check("t6_usage2", usage0, 2);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t6_hwm_clr", hwm0, 2);
        check("t6_ovf_clr", ovf0, 0);
        push_n(6, 8'h37);
        clr = 1'b1; b0.p_vld = 1'b1; b0.p_data = 8'h3D;
        tick();
        clr = 1'b0; b0.p_vld = 1'b0;
        check("t6_ovf_drop", ovf0, 1);
        check("t6_hwm_drop", hwm0, 8);

        // 4: wrap on the depth-6 instance
        rx_en = 1'b1; rx_cnt = 0;
        b1.c_drdy = 1'b1;
        check("t4_srdy_pre", b1.c_srdy, 0);
        for (int i = 0; i < 20; i++) begin
            b1.p_vld = 1'b1; b1.p_data = 8'h40 + 8'(i);
            tick();
            if (i == 0) check("t4_srdy_rise", b1.c_srdy, 1);
        end
        b1.p_vld = 1'b0;
        tick(); tick();
        rx_en = 1'b0;
        check("t4_count", rx_cnt, 20);
        check("t4_ovf", ovf1, 0);
        b1.c_drdy = 1'b0;

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clr       = ($urandom_range(0, 49) == 0);
            b0.p_vld  = ($urandom_range(0, 9) < 6);
            b0.p_data = 8'($urandom);
            b0.c_drdy = ($urandom_range(0, 9) < 5);
            b1.p_vld  = ($urandom_range(0, 9) < 5);
            b1.p_data = 8'($urandom);
            b1.c_drdy = ($urandom_range(0, 9) < 5);
            tick();
        end
        rst = 1'b0; clr = 1'b0;
        b0.p_vld = 1'b0; b1.p_vld = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
